// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the booth_mult4 sequential multiplier.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_W      = 4;
    localparam int RES_W     = 2 * OP_W;
    localparam int CNT_W     = 3;
    localparam int LAST_STEP = 3;

endpackage

// File: rtl/booth_mult4_iter_counter.sv
// Iteration counter for the Booth step loop: 3-bit up-counter that
// saturates at its all-ones value and flags when it reaches max_number.
module iter_counter
    import booth_mult_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] max_number,
    output logic             bigger_than_max
);

    logic [CNT_W-1:0] count_q;

    // Count up every cycle out of reset, holding at the top value instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bigger_than_max = (count_q >= max_number);

endmodule

// File: rtl/booth_mult4.sv
// Sequential signed multiplier using radix-2 Booth recoding, one step per
// clock, with a start/done handshake.
// Optional simulation trace of state transitions: define BOOTH_MULT_TRACE_EN.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   CALC  | one Booth add/sub + arithmetic shift per cycle
//   DONE  | product copied to ab_result, done pulsed
module booth_mult4
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = OP_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] ab_result,
    output logic               done,
    output logic               busy
);

    // P holds {upper accumulator (WIDTH+1), multiplier (WIDTH), previous bit}.
    localparam int PW = 2 * WIDTH + 2;

    state_t             state_q;
    logic [PW-1:0]      p_q;
    logic [PW-1:0]      p_d;
    logic [WIDTH:0]     m_q;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] result_q;
    logic               done_q;
    logic               init_count;
    logic               cnt_reset;
    logic               bigger_than_max;

    // Counter only runs while stepping; it sits at zero everywhere else.
    assign init_count = (state_q == CALC);
    assign cnt_reset  = !init_count || reset;

    iter_counter u_iter (
        .clock           (clock),
        .reset           (cnt_reset),
        .max_number      (CNT_W'(LAST_STEP)),
        .bigger_than_max (bigger_than_max)
    );

    // One Booth step: recode the two LSBs, add/sub M in the upper field, then shift.
    // The upper field is one bit wider than M so -(-8) = +8 does not overflow.
    always_comb begin
        upper_sum = p_q[PW-1:WIDTH+1];
        case (p_q[1:0])
            2'b01:   upper_sum = p_q[PW-1:WIDTH+1] + m_q;
            2'b10:   upper_sum = p_q[PW-1:WIDTH+1] - m_q;
            default: upper_sum = p_q[PW-1:WIDTH+1];
        endcase
        p_d = {upper_sum[WIDTH], upper_sum, p_q[WIDTH:1]};
    end

    // Control FSM with registered product and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            p_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= {a[WIDTH-1], a};
                        p_q     <= {{(WIDTH + 1){1'b0}}, b, 1'b0};
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    p_q <= p_d;
                    if (bigger_than_max) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_q <= p_q[2*WIDTH:1];
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ab_result = result_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

`ifdef BOOTH_MULT_TRACE_EN
    state_t trace_state_q;

    // Report each state change once, the cycle the new state becomes visible.
    always @(posedge clock) begin
        trace_state_q <= state_q;
        if (trace_state_q != state_q) begin
            $display("[booth_mult4] t=%0t state=%s count=%0d P=0x%0h M=0x%0h",
                     $time, state_q.name(), u_iter.count_q, p_q, m_q);
        end
    end
`else
    // Trace disabled: no extra logic.
`endif

endmodule

// File: tb/tb_booth_mult4.sv
module tb_booth_mult4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] ab_result;
    logic       done;
    logic       busy;

    int tests = 0;
    int fails = 0;

    booth_mult4 dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ab_result (ab_result),
        .done      (done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launch one operation from IDLE and check latency, product and pulse width.
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                          input logic [7:0] exp, input string name);
        int lat;
        a     = ia;
        b     = ib;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, " busy"}, {7'b0, busy}, 8'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, 8'(lat), 8'd5);
        check({name, " result"}, ab_result, exp);
        step();
        check({name, " done_1cyc"}, {7'b0, done}, 8'd0);
        check({name, " hold"}, ab_result, exp);
    endtask

    initial begin
        int lat;
        int seen_done;
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        int prod;

        vecs[0] = '{4'd4,  4'd3,  8'h0C, "4x3"};
        vecs[1] = '{4'hD,  4'd5,  8'hF1, "-3x5"};
        vecs[2] = '{4'h8,  4'h8,  8'h40, "-8x-8"};
        vecs[3] = '{4'd7,  4'h8,  8'hC8, "7x-8"};
        vecs[4] = '{4'd0,  4'h9,  8'h00, "0x-7"};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) step();
        reset = 1'b0;
        check("rst ab_result", ab_result, 8'h00);
        check("rst done", {7'b0, done}, 8'd0);
        check("rst busy", {7'b0, busy}, 8'd0);

        // start held for three accepted-cycle edges; only one operation results
        a     = 4'd4;
        b     = 4'd3;
        start = 1'b1;
        step();
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) start = 1'b0;
            step();
            if (done) begin
                lat = k;
                break;
            end
            check("held no early done", {7'b0, done}, 8'd0);
        end
        check("held latency", 8'(lat), 8'd5);
        check("held result", ab_result, 8'h0C);
        step();
        run_op(4'd4, 4'd3, 8'h0C, "second 4x3");

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // reset mid-CALC aborts: no done, result cleared
        a     = 4'd3;
        b     = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("abort busy", {7'b0, busy}, 8'd0);
        check("abort result", ab_result, 8'h00);
        check("abort done", {7'b0, done}, 8'd0);
        reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done) seen_done++;
        end
        check("abort no done later", 8'(seen_done), 8'd0);
        run_op(4'd2, 4'hF, 8'hFE, "2x-1 after abort");

        // operands change and start pulses during CALC are ignored
        a     = 4'd4;
        b     = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 4'd7;
        b     = 4'd7;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 2;
        for (int k = 3; k <= 20; k++) begin
            step();
            if (done) begin
                lat = k;
                break;
            end
        end
        check("opchg latency", 8'(lat), 8'd5);
        check("opchg result", ab_result, 8'h0C);
        step();
        check("opchg idle", {7'b0, busy}, 8'd0);

        // exhaustive sweep against the signed reference product
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa   = 4'(i);
                sb   = 4'(j);
                prod = int'(sa) * int'(sb);
                run_op(4'(i), 4'(j), prod[7:0], $sformatf("sweep %0d*%0d", sa, sb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
